// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: frame sequencer for the block-stacking game.
// It turns each speed-counter tick into an erase / shift / draw sequence,
// services player drops through a landing-check handshake, and raises the
// difficulty every DROPS_PER_LEVEL successful drops.
// Optional feature macro: HANDSHAKE_WATCHDOG_EN (watchdog on erase/draw waits).
module game_tick_scheduler #(
    parameter logic [2:0]  START_DIFF      = 3'd7,
    parameter logic [2:0]  MIN_DIFF        = 3'd1,
    parameter int          DROPS_PER_LEVEL = 4,
    parameter logic [19:0] TIMEOUT_CYCLES  = 20'd1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       tick,
    input  logic       drop,
    input  logic       erase_done,
    input  logic       draw_done,
    input  logic       check_valid,
    input  logic       check_hit,
    output logic       spd_load,
    output logic [2:0] spd_difficulty,
    output logic       erase_req,
    output logic       shift_en,
    output logic       draw_req,
    output logic       check_req,
    output logic       spawn,
    output logic [2:0] level,
    output logic [7:0] score,
    output logic       game_over,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ERASE,
        S_SHIFT,
        S_DRAW,
        S_CHECK,
        S_NEXT,
        S_OVER
    } state_t;

    localparam logic [3:0] DPL = DROPS_PER_LEVEL[3:0];

    state_t     state_reg, state_next;
    logic [2:0] diff_reg, diff_next;
    logic [2:0] level_reg, level_next;
    logic [7:0] score_reg, score_next;
    logic [3:0] drop_cnt_reg, drop_cnt_next;
    logic       drop_pending_reg, drop_pending_next;
    logic       erase_req_reg, shift_en_reg, draw_req_reg, check_req_reg;
    logic       spd_load_reg, spawn_reg, game_over_reg;
    logic       wd_expire;

`ifdef HANDSHAKE_WATCHDOG_EN
    logic [19:0] wd_cnt_reg;
    logic        fault_reg;

    // Expire only while genuinely waiting: a done arriving on the last
    // cycle takes the normal path and does not flag a fault.
    assign wd_expire = ((state_reg == S_ERASE && !erase_done) ||
                        (state_reg == S_DRAW  && !draw_done)) &&
                       (wd_cnt_reg == TIMEOUT_CYCLES - 20'd1);

    // Watchdog counter restarts on entry to a wait state; fault is sticky.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_reg <= '0;
            fault_reg  <= 1'b0;
        end else begin
            if (state_next != state_reg &&
                (state_next == S_ERASE || state_next == S_DRAW))
                wd_cnt_reg <= '0;
            else if (state_reg == S_ERASE || state_reg == S_DRAW)
                wd_cnt_reg <= wd_cnt_reg + 20'd1;
            if (wd_expire)
                fault_reg <= 1'b1;
        end
    end

    assign fault = fault_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wd_expire      = 1'b0;
    assign fault          = 1'b0;
`endif

    // Next-state and game-datapath logic.
    always_comb begin
        state_next        = state_reg;
        diff_next         = diff_reg;
        level_next        = level_reg;
        score_next        = score_reg;
        drop_cnt_next     = drop_cnt_reg;
        drop_pending_next = drop_pending_reg;

        case (state_reg)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_next    = S_NEXT;
                    diff_next     = START_DIFF;
                    level_next    = 3'd0;
                    score_next    = 8'd0;
                    drop_cnt_next = 4'd0;
                end
            end
            S_WAIT: begin
                // A drop beats a coincident tick; that tick is lost.
                if (drop_pending_reg || drop)
                    state_next = S_CHECK;
                else if (tick)
                    state_next = S_ERASE;
            end
            S_ERASE: begin
                if (erase_done || wd_expire)
                    state_next = S_SHIFT;
            end
            S_SHIFT: state_next = S_DRAW;
            S_DRAW: begin
                if (draw_done || wd_expire)
                    state_next = S_WAIT;
            end
            S_CHECK: begin
                if (check_valid) begin
                    if (check_hit) begin
                        state_next = S_NEXT;
                        if (score_reg != 8'hFF)
                            score_next = score_reg + 8'd1;
                        if (drop_cnt_reg + 4'd1 == DPL) begin
                            drop_cnt_next = 4'd0;
                            if (level_reg != 3'd7)
                                level_next = level_reg + 3'd1;
                            diff_next = (diff_reg > MIN_DIFF) ? diff_reg - 3'd1 : MIN_DIFF;
                        end else begin
                            drop_cnt_next = drop_cnt_reg + 4'd1;
                        end
                    end else begin
                        state_next = S_OVER;
                    end
                end
            end
            S_NEXT: state_next = S_DRAW;
            default: state_next = S_IDLE;
        endcase

        // Drops that land mid-sequence are remembered (collapsed to one)
        // and serviced at the next WAIT; entering CHECK consumes them.
        if (state_reg == S_ERASE || state_reg == S_SHIFT || state_reg == S_DRAW ||
            state_reg == S_CHECK || state_reg == S_NEXT) begin
            if (drop)
                drop_pending_next = 1'b1;
        end
        if (state_next == S_CHECK && state_reg != S_CHECK)
            drop_pending_next = 1'b0;
    end

    // State, datapath and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= S_IDLE;
            diff_reg         <= START_DIFF;
            level_reg        <= 3'd0;
            score_reg        <= 8'd0;
            drop_cnt_reg     <= 4'd0;
            drop_pending_reg <= 1'b0;
            erase_req_reg    <= 1'b0;
            shift_en_reg     <= 1'b0;
            draw_req_reg     <= 1'b0;
            check_req_reg    <= 1'b0;
            spd_load_reg     <= 1'b0;
            spawn_reg        <= 1'b0;
            game_over_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            diff_reg         <= diff_next;
            level_reg        <= level_next;
            score_reg        <= score_next;
            drop_cnt_reg     <= drop_cnt_next;
            drop_pending_reg <= drop_pending_next;
            erase_req_reg    <= (state_next == S_ERASE);
            shift_en_reg     <= (state_next == S_SHIFT);
            draw_req_reg     <= (state_next == S_DRAW);
            check_req_reg    <= (state_next == S_CHECK) && (state_reg != S_CHECK);
            spd_load_reg     <= (state_next == S_NEXT);
            spawn_reg        <= (state_next == S_NEXT);
            game_over_reg    <= (state_next == S_OVER);
        end
    end

    assign spd_load       = spd_load_reg;
    assign spd_difficulty = diff_reg;
    assign erase_req      = erase_req_reg;
    assign shift_en       = shift_en_reg;
    assign draw_req       = draw_req_reg;
    assign check_req      = check_req_reg;
    assign spawn          = spawn_reg;
    assign level          = level_reg;
    assign score          = score_reg;
    assign game_over      = game_over_reg;

endmodule
